idex_forward_stage: RTL and testbench

- ID/EX pipeline register plus execute-stage operand forwarding for the 5-stage RV32 pipeline.
- Captures decoded operands and control from Decode; drives the ALU's a/b/alucontrol inputs through forwarding muxes.
- Consumes the ALU's ZeroE to resolve branch/jump redirect (PCSrcE, PCTargetE).
- Exposes Rs1E/Rs2E/RdE to the hazard unit.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/idex_forward_stage_flopenrc.sv | 21 ++
 rtl/idex_forward_stage.sv | 128 ++++++++++++
 tb/tb_idex_forward_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: default widths, forwarding selects, ALU and
// writeback encodings, and the ID/EX control bundle.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_RAW  = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // valid is part of the control bundle so a flush clears it with everything else
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       valid;
  } ctrl_t;

endpackage

// File: rtl/idex_forward_stage_flopenrc.sv
// Pipeline register with async reset, synchronous clear and enable.
// Priority: reset > clear > enable.
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/idex_forward_stage.sv
// ID/EX pipeline register with execute-stage operand forwarding and
// branch/jump redirect resolution.
module idex_forward_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int RAW  = DEFAULT_RAW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [RAW-1:0]  Rs1D,
  input  logic [RAW-1:0]  Rs2D,
  input  logic [RAW-1:0]  RdD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic            ZeroE,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] PCTargetE,
  output logic [RAW-1:0]  Rs1E,
  output logic [RAW-1:0]  Rs2E,
  output logic [RAW-1:0]  RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            PCSrcE,
  output logic            ValidE
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
  } data_t;

  data_t data_d, data_e;
  ctrl_t ctrl_d, ctrl_e;
  logic  load_en;
  logic [XLEN-1:0] fwd_a, fwd_b;

  assign load_en = ~StallE;

  assign data_d = '{rd1: RD1D, rd2: RD2D, pc: PCD, pc_plus4: PCPlus4D,
                    imm_ext: ImmExtD, rs1: Rs1D, rs2: Rs2D, rd: RdD};

  assign ctrl_d = '{reg_write: RegWriteD, mem_write: MemWriteD, jump: JumpD,
                    branch: BranchD, alu_src: ALUSrcD, result_src: ResultSrcD,
                    alu_control: ALUControlD, valid: 1'b1};

  flopenrc #(.WIDTH($bits(data_t))) u_data_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clear (FlushE),
    .d     (data_d),
    .q     (data_e)
  );

  flopenrc #(.WIDTH($bits(ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clear (FlushE),
    .d     (ctrl_d),
    .q     (ctrl_e)
  );

  // The reserved select 2'b11 falls into the default and keeps the register value.
  // NOTE: each output is assigned a default first so no path can infer a latch.
  always_comb begin
    fwd_a = data_e.rd1;
    case (fwd_sel_t'(ForwardAE))
      FWD_MEM: fwd_a = ALUResultM;
      FWD_WB:  fwd_a = ResultW;
      default: ;
    endcase
  end

  always_comb begin
    fwd_b = data_e.rd2;
    case (fwd_sel_t'(ForwardBE))
      FWD_MEM: fwd_b = ALUResultM;
      FWD_WB:  fwd_b = ResultW;
      default: ;
    endcase
  end

  assign SrcAE      = fwd_a;
  assign WriteDataE = fwd_b;
  assign SrcBE      = ctrl_e.alu_src ? data_e.imm_ext : fwd_b;
  assign PCTargetE  = data_e.pc + data_e.imm_ext;
  assign PCSrcE     = ctrl_e.jump | (ctrl_e.branch & ZeroE);

  assign ALUControlE = ctrl_e.alu_control;
  assign PCPlus4E    = data_e.pc_plus4;
  assign Rs1E        = data_e.rs1;
  assign Rs2E        = data_e.rs2;
  assign RdE         = data_e.rd;
  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign ResultSrcE  = ctrl_e.result_src;
  assign ValidE      = ctrl_e.valid;

endmodule

// File: tb/tb_idex_forward_stage.sv
// Directed bench for idex_forward_stage: expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_idex_forward_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;
  logic        ZeroE;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, PCSrcE, ValidE;
  logic [1:0]  ResultSrcE;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  idex_forward_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .ZeroE(ZeroE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .ValidE(ValidE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected queued entry", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    RD1D = '0; RD2D = '0; PCD = '0; PCPlus4D = '0; ImmExtD = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = RESULT_ALU; ALUControlD = ALU_ADD;
  endtask

  initial begin
    // Reset with nonzero D inputs, sampled before any clock edge.
    reset = 1; StallE = 0; FlushE = 0;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUResultM = 32'hAAAA_0000; ResultW = 32'hBBBB_0000; ZeroE = 1;
    RD1D = 32'h55; RD2D = 32'h66; PCD = 32'h400; PCPlus4D = 32'h404; ImmExtD = 32'h8;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
    RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; ALUSrcD = 1;
    ResultSrcD = RESULT_MEM; ALUControlD = ALU_SUB;
    #2;
    expect_val("rst_srca", 32'h0);      check(SrcAE);
    expect_val("rst_srcb", 32'h0);      check(SrcBE);
    expect_val("rst_wdata", 32'h0);     check(WriteDataE);
    expect_val("rst_target", 32'h0);    check(PCTargetE);
    expect_val("rst_pcsrc", 32'h0);     check({31'b0, PCSrcE});
    expect_val("rst_valid", 32'h0);     check({31'b0, ValidE});
    expect_val("rst_regwrite", 32'h0);  check({31'b0, RegWriteE});
    expect_val("rst_rd", 32'h0);        check({27'b0, RdE});

    @(negedge clk);
    reset = 0;

    // Plain load, no forwarding.
    drive_nop();
    RD1D = 32'd5; RD2D = 32'd7; ALUSrcD = 0; ALUControlD = ALU_SUB;
    PCD = 32'h1000; PCPlus4D = 32'h1004; ImmExtD = 32'h10;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; RegWriteD = 1; ResultSrcD = RESULT_PC4;
    tick();
    expect_val("load_srca", 32'd5);        check(SrcAE);
    expect_val("load_srcb", 32'd7);        check(SrcBE);
    expect_val("load_aluctl", 32'd1);      check({29'b0, ALUControlE});
    expect_val("load_valid", 32'd1);       check({31'b0, ValidE});
    expect_val("load_target", 32'h1010);   check(PCTargetE);
    expect_val("load_pcplus4", 32'h1004);  check(PCPlus4E);
    expect_val("load_rs1", 32'd1);         check({27'b0, Rs1E});
    expect_val("load_rs2", 32'd2);         check({27'b0, Rs2E});
    expect_val("load_resultsrc", 32'd2);   check({30'b0, ResultSrcE});

    // Forward A from Memory.
    ForwardAE = 2'b10; ALUResultM = 32'h100; #1;
    expect_val("fwd_a_mem", 32'h100);      check(SrcAE);
    expect_val("fwd_a_mem_b", 32'd7);      check(SrcBE);

    // Forward B from Writeback.
    ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'h22; #1;
    expect_val("fwd_b_wb_srcb", 32'h22);   check(SrcBE);
    expect_val("fwd_b_wb_wdata", 32'h22);  check(WriteDataE);
    expect_val("fwd_b_wb_a", 32'd5);       check(SrcAE);

    // Reserved select behaves as register value.
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    ALUResultM = 32'hDEAD_0001; ResultW = 32'hBEEF_0002; #1;
    expect_val("fwd_a_rsvd", 32'd5);       check(SrcAE);
    expect_val("fwd_b_rsvd", 32'd7);       check(WriteDataE);
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // Immediate operand and PC target wrap.
    @(negedge clk);
    drive_nop();
    ALUSrcD = 1; ImmExtD = 32'hFFFF_FFFC; RD2D = 32'd9; PCD = 32'h2;
    ALUControlD = ALU_SLT;
    tick();
    expect_val("imm_srcb", 32'hFFFF_FFFC); check(SrcBE);
    expect_val("imm_wdata", 32'd9);        check(WriteDataE);
    expect_val("imm_target", 32'hFFFF_FFFE); check(PCTargetE);
    expect_val("imm_aluctl", 32'd5);       check({29'b0, ALUControlE});

    // Branch resolution.
    @(negedge clk);
    drive_nop();
    BranchD = 1; ZeroE = 1;
    tick();
    expect_val("br_taken", 32'd1);         check({31'b0, PCSrcE});
    ZeroE = 0; #1;
    expect_val("br_not_taken", 32'd0);     check({31'b0, PCSrcE});

    @(negedge clk);
    drive_nop();
    JumpD = 1; ZeroE = 0;
    tick();
    expect_val("jump", 32'd1);             check({31'b0, PCSrcE});

    // Stall holds all fields while D inputs change.
    @(negedge clk);
    drive_nop();
    RD1D = 32'h11; RdD = 5'd7; RegWriteD = 1; MemWriteD = 1; ALUControlD = ALU_OR;
    tick();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      RD1D = 32'h900 + i; RdD = 5'd20 + 5'(i); RegWriteD = 0; MemWriteD = 0;
      ALUControlD = ALU_AND; JumpD = 1;
      tick();
      expect_val("stall_srca", 32'h11);    check(SrcAE);
      expect_val("stall_rd", 32'd7);       check({27'b0, RdE});
      expect_val("stall_memwrite", 32'd1); check({31'b0, MemWriteE});
      expect_val("stall_aluctl", 32'd3);   check({29'b0, ALUControlE});
      expect_val("stall_pcsrc", 32'd0);    check({31'b0, PCSrcE});
    end

    // Flush beats stall on the same edge.
    FlushE = 1;
    tick();
    expect_val("flush_regwrite", 32'd0);   check({31'b0, RegWriteE});
    expect_val("flush_memwrite", 32'd0);   check({31'b0, MemWriteE});
    expect_val("flush_rd", 32'd0);         check({27'b0, RdE});
    expect_val("flush_valid", 32'd0);      check({31'b0, ValidE});
    expect_val("flush_pcsrc", 32'd0);      check({31'b0, PCSrcE});
    FlushE = 0; StallE = 0;

    // Reset asserted mid-stall clears state without a clock edge.
    @(negedge clk);
    drive_nop();
    RD1D = 32'h77; RdD = 5'd9; JumpD = 1;
    tick();
    expect_val("pre_rst_srca", 32'h77);    check(SrcAE);
    StallE = 1;
    #2 reset = 1;
    #1;
    expect_val("midrst_srca", 32'h0);      check(SrcAE);
    expect_val("midrst_valid", 32'd0);     check({31'b0, ValidE});
    expect_val("midrst_pcsrc", 32'd0);     check({31'b0, PCSrcE});
    @(negedge clk);
    reset = 0; StallE = 0;
    tick();
    expect_val("post_rst_load", 32'h77);   check(SrcAE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
